// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life generation stepper.
// Used by life_word_eval and life_stepper.
package life_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_CAP,
        ST_WR,
        ST_FIN
    } state_e;

    typedef logic [3:0] nbr_cnt_t;
    typedef logic [8:0] rule_mask_t;

    // Bit n of a mask is the outcome for a cell with n live neighbours.
    localparam rule_mask_t BIRTH_DEFAULT   = 9'b000001000;
    localparam rule_mask_t SURVIVE_DEFAULT = 9'b000001100;

endpackage

// File: rtl/life_word_eval.sv
// Combinational next-generation evaluator for one board word, given the
// 3x3 word window around it (rows above/current/below, words left/centre/right).
module life_word_eval
    import life_pkg::*;
#(
    parameter int LINE_WIDTH = 8
) (
    input  logic [LINE_WIDTH-1:0] left_in   [3],
    input  logic [LINE_WIDTH-1:0] centre_in [3],
    input  logic [LINE_WIDTH-1:0] right_in  [3],
    input  rule_mask_t            birth_mask_in,
    input  rule_mask_t            survive_mask_in,
    output logic [LINE_WIDTH-1:0] next_word_out
);

    // Each row extended by the seam cell on either side: ext[0] is the left
    // word's MSB, ext[LINE_WIDTH+1] is the right word's LSB.
    logic [LINE_WIDTH+1:0] ext [3];

    for (genvar rr = 0; rr < 3; rr++) begin : g_row
        assign ext[rr] = {right_in[rr][0], centre_in[rr], left_in[rr][LINE_WIDTH-1]};
    end

    for (genvar i = 0; i < LINE_WIDTH; i++) begin : g_cell
        nbr_cnt_t n;
        assign n = nbr_cnt_t'(ext[0][i]) + nbr_cnt_t'(ext[0][i+1]) + nbr_cnt_t'(ext[0][i+2])
                 + nbr_cnt_t'(ext[1][i])                           + nbr_cnt_t'(ext[1][i+2])
                 + nbr_cnt_t'(ext[2][i]) + nbr_cnt_t'(ext[2][i+1]) + nbr_cnt_t'(ext[2][i+2]);
        assign next_word_out[i] = centre_in[1][i] ? survive_mask_in[n] : birth_mask_in[n];
    end

endmodule

// File: rtl/life_stepper.sv
// One Game-of-Life generation per start pulse over a ping-pong board RAM (toroidal board).
// Define LIFE_RULE_CFG_EN to add birth/survive mask ports; otherwise the rule is fixed B3/S23.
module life_stepper
    import life_pkg::*;
#(
    parameter int ADDR_SIZE     = 32,
    parameter int LINE_WIDTH    = 8,
    parameter int BOARD_W_WORDS = 80,
    parameter int BOARD_H       = 480
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [LINE_WIDTH-1:0] data_r_in,
`ifdef LIFE_RULE_CFG_EN
    input  rule_mask_t            birth_mask_in,
    input  rule_mask_t            survive_mask_in,
`endif
    output logic [ADDR_SIZE-1:0]  addr_r_out,
    output logic [ADDR_SIZE-1:0]  addr_w_out,
    output logic [LINE_WIDTH-1:0] data_w_out,
    output logic                  we_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  buf_sel_out
);

    typedef logic [ADDR_SIZE-1:0]  addr_t;
    typedef logic [LINE_WIDTH-1:0] word_t;

    localparam addr_t ONE        = addr_t'(1);
    localparam addr_t W          = addr_t'(BOARD_W_WORDS);
    localparam addr_t LAST_ROW   = addr_t'(BOARD_H - 1);
    localparam addr_t BANK_WORDS = addr_t'(BOARD_W_WORDS * BOARD_H);

    state_e     state_q, state_d;
    addr_t      row_q, row_d, col_q, col_d;
    addr_t      prev_base_q, prev_base_d, cur_base_q, cur_base_d, next_base_q, next_base_d;
    logic [2:0] prime_cnt_q, prime_cnt_d;
    addr_t      addr_r_q, addr_r_d, addr_w_q, addr_w_d;
    word_t      data_w_q, data_w_d;
    logic       buf_sel_q, buf_sel_d;
    word_t      win_l_q [3], win_l_d [3];
    word_t      win_c_q [3], win_c_d [3];
    word_t      win_r_q [3], win_r_d [3];
    word_t      eval_r [3];
    word_t      next_word;
    addr_t      rd_bank_base, wr_bank_base, col_p1, col_p2;
    addr_t      rd_row [3];
    rule_mask_t birth_mask, survive_mask;

`ifdef LIFE_RULE_CFG_EN
    rule_mask_t birth_q, birth_d, survive_q, survive_d;
    assign birth_mask   = birth_q;
    assign survive_mask = survive_q;
`else
    assign birth_mask   = BIRTH_DEFAULT;
    assign survive_mask = SURVIVE_DEFAULT;
`endif

    function automatic addr_t wrap_inc(input addr_t v, input addr_t lim);
        return (v == lim - ONE) ? '0 : v + ONE;
    endfunction

    function automatic addr_t next_row_base(input addr_t b);
        return (b + W == BANK_WORDS) ? '0 : b + W;
    endfunction

    assign rd_bank_base = buf_sel_q ? BANK_WORDS : '0;
    assign wr_bank_base = buf_sel_q ? '0 : BANK_WORDS;
    assign rd_row[0]    = rd_bank_base + prev_base_q;
    assign rd_row[1]    = rd_bank_base + cur_base_q;
    assign rd_row[2]    = rd_bank_base + next_base_q;
    assign col_p1       = wrap_inc(col_q, W);
    assign col_p2       = wrap_inc(col_p1, W);

    // The bottom-right word arrives in CAP; bypass it so the result can be registered for WR.
    assign eval_r = '{win_r_q[0], win_r_q[1], data_r_in};

    life_word_eval #(.LINE_WIDTH(LINE_WIDTH)) u_eval (
        .left_in        (win_l_q),
        .centre_in      (win_c_q),
        .right_in       (eval_r),
        .birth_mask_in  (birth_mask),
        .survive_mask_in(survive_mask),
        .next_word_out  (next_word)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        prev_base_d = prev_base_q;
        cur_base_d  = cur_base_q;
        next_base_d = next_base_q;
        prime_cnt_d = prime_cnt_q;
        addr_r_d    = addr_r_q;
        addr_w_d    = addr_w_q;
        data_w_d    = data_w_q;
        buf_sel_d   = buf_sel_q;
        win_l_d     = win_l_q;
        win_c_d     = win_c_q;
        win_r_d     = win_r_q;
`ifdef LIFE_RULE_CFG_EN
        birth_d     = birth_q;
        survive_d   = survive_q;
`endif
        unique case (state_q)
            ST_IDLE: if (start_in) begin
                state_d     = ST_PRIME;
                row_d       = '0;
                col_d       = '0;
                prime_cnt_d = '0;
                prev_base_d = BANK_WORDS - W;
                cur_base_d  = '0;
                next_base_d = next_row_base('0);
                addr_r_d    = rd_bank_base + BANK_WORDS - ONE;  // row H-1, word W-1
`ifdef LIFE_RULE_CFG_EN
                birth_d     = birth_mask_in;
                survive_d   = survive_mask_in;
`endif
            end
            ST_PRIME: begin
                unique case (prime_cnt_q)
                    3'd1:    win_l_d[0] = data_r_in;
                    3'd2:    win_l_d[1] = data_r_in;
                    3'd3:    win_l_d[2] = data_r_in;
                    3'd4:    win_c_d[0] = data_r_in;
                    3'd5:    win_c_d[1] = data_r_in;
                    3'd6:    win_c_d[2] = data_r_in;
                    default: ;
                endcase
                unique case (prime_cnt_q)
                    3'd0:    addr_r_d = rd_row[1] + W - ONE;
                    3'd1:    addr_r_d = rd_row[2] + W - ONE;
                    3'd2:    addr_r_d = rd_row[0];
                    3'd3:    addr_r_d = rd_row[1];
                    3'd4:    addr_r_d = rd_row[2];
                    3'd6:    addr_r_d = rd_row[0] + col_p1;
                    default: ;
                endcase
                if (prime_cnt_q == 3'd6) state_d = ST_RD0;
                else                     prime_cnt_d = prime_cnt_q + 3'd1;
            end
            ST_RD0: begin
                addr_r_d = rd_row[1] + col_p1;
                state_d  = ST_RD1;
            end
            ST_RD1: begin
                win_r_d[0] = data_r_in;
                addr_r_d   = rd_row[2] + col_p1;
                state_d    = ST_RD2;
            end
            ST_RD2: begin
                win_r_d[1] = data_r_in;
                state_d    = ST_CAP;
            end
            ST_CAP: begin
                win_r_d[2] = data_r_in;
                data_w_d   = next_word;
                addr_w_d   = wr_bank_base + cur_base_q + col_q;
                state_d    = ST_WR;
            end
            ST_WR: begin
                win_l_d = win_c_q;
                win_c_d = win_r_q;
                if (col_q != W - ONE) begin
                    col_d    = col_p1;
                    addr_r_d = rd_row[0] + col_p2;
                    state_d  = ST_RD0;
                end else if (row_q != LAST_ROW) begin
                    row_d       = row_q + ONE;
                    col_d       = '0;
                    prime_cnt_d = '0;
                    prev_base_d = cur_base_q;
                    cur_base_d  = next_base_q;
                    next_base_d = next_row_base(next_base_q);
                    addr_r_d    = rd_row[1] + W - ONE;  // old current row is the new row above
                    state_d     = ST_PRIME;
                end else begin
                    buf_sel_d = ~buf_sel_q;
                    state_d   = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            prev_base_q <= '0;
            cur_base_q  <= '0;
            next_base_q <= '0;
            prime_cnt_q <= '0;
            addr_r_q    <= '0;
            addr_w_q    <= '0;
            data_w_q    <= '0;
            buf_sel_q   <= 1'b0;
`ifdef LIFE_RULE_CFG_EN
            birth_q     <= BIRTH_DEFAULT;
            survive_q   <= SURVIVE_DEFAULT;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            prev_base_q <= prev_base_d;
            cur_base_q  <= cur_base_d;
            next_base_q <= next_base_d;
            prime_cnt_q <= prime_cnt_d;
            addr_r_q    <= addr_r_d;
            addr_w_q    <= addr_w_d;
            data_w_q    <= data_w_d;
            buf_sel_q   <= buf_sel_d;
`ifdef LIFE_RULE_CFG_EN
            birth_q     <= birth_d;
            survive_q   <= survive_d;
`endif
        end
    end

    // NOTE: the window is always refilled by PRIME before it is read, so it carries no reset.
    always_ff @(posedge clk_in) begin
        win_l_q <= win_l_d;
        win_c_q <= win_c_d;
        win_r_q <= win_r_d;
    end

    assign addr_r_out  = addr_r_q;
    assign addr_w_out  = addr_w_q;
    assign data_w_out  = data_w_q;
    assign we_out      = (state_q == ST_WR);
    assign busy_out    = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done_out    = (state_q == ST_FIN);
    assign buf_sel_out = buf_sel_q;

endmodule

// File: tb/tb_life_stepper.sv
// Self-checking bench for life_stepper on a 16x4-cell torus (W=2, H=4, 8-cell words)
// with a 1-cycle-latency RAM model, a reference Life model and a write scoreboard.
module tb_life_stepper;

    localparam int AW      = 16;
    localparam int GEN_CYC = 4 * (7 + 5 * 2) + 1;
    localparam int MAX_CYC = 150;

    typedef struct packed {
        logic [63:0] init_b;
        logic [3:0]  gens;
        logic [63:0] final_b;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk, rst_n_in, start_in;
    logic [7:0]    data_r_in;
    logic [AW-1:0] addr_r_out, addr_w_out;
    logic [7:0]    data_w_out;
    logic          we_out, busy_out, done_out, buf_sel_out;
    logic [8:0]    birth_mask, survive_mask;

    logic [7:0]    mem [16];
    logic          load_go;
    logic [63:0]   load_img;
    logic [63:0]   model_b;
    logic          exp_bank;
    wr_t           exp_q [$];
    vec_t          vecs [4];
    int            n_cmp, n_bad, we_seen;

    life_stepper #(
        .ADDR_SIZE    (AW),
        .LINE_WIDTH   (8),
        .BOARD_W_WORDS(2),
        .BOARD_H      (4)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .data_r_in      (data_r_in),
`ifdef LIFE_RULE_CFG_EN
        .birth_mask_in  (birth_mask),
        .survive_mask_in(survive_mask),
`endif
        .addr_r_out     (addr_r_out),
        .addr_w_out     (addr_w_out),
        .data_w_out     (data_w_out),
        .we_out         (we_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .buf_sel_out    (buf_sel_out)
    );

    always #5 clk = ~clk;

    // RAM model: bank 0 words 0..7, bank 1 words 8..15, registered read data.
    always @(posedge clk) begin
        data_r_in <= mem[addr_r_out[3:0]];
        if (we_out) mem[addr_w_out[3:0]] <= data_w_out;
        if (load_go) begin
            for (int k = 0; k < 8; k++) begin
                mem[k]     <= load_img[8*k +: 8];
                mem[k + 8] <= 8'hA5;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the next expected word.
    always @(negedge clk) begin
        if (rst_n_in && we_out) begin
            we_seen++;
            check("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(addr_w_out), 64'(e.addr));
                check("write_data", 64'(data_w_out), 64'(e.data));
            end
        end
    end

    // Reference: cell (x,y) is bit y*16+x of the 64-bit board image.
    function automatic logic [63:0] life_step(input logic [63:0] b, input logic [8:0] bm,
                                              input logic [8:0] sm);
        logic [63:0] nb;
        nb = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 16; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0)
                            n += int'(b[((y + dy + 4) % 4) * 16 + (x + dx + 16) % 16]);
                nb[y*16 + x] = b[y*16 + x] ? sm[n] : bm[n];
            end
        end
        return nb;
    endfunction

    function automatic logic [63:0] bank_img(input logic sel);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = mem[(sel ? 8 : 0) + k];
        return r;
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, 64'({addr_r_out, addr_w_out, data_w_out, we_out, busy_out, done_out}), 64'd0);
        check({name, "_buf_sel"}, 64'(buf_sel_out), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_in = 1'b0;
        #1 check_reset_outputs("reset_outputs");
        @(negedge clk);
        rst_n_in = 1'b1;
        exp_q.delete();
        exp_bank = 1'b0;
    endtask

    task automatic load_board(input logic [63:0] b);
        load_img = b;
        load_go  = 1'b1;
        @(posedge clk);
        #1 load_go = 1'b0;
        model_b = b;
    endtask

    // One generation; extra start pulses at cycles xs0..xs2, optional async reset at rst_at.
    task automatic run_gen(input int xs0, input int xs1, input int xs2, input int rst_at);
        logic [63:0] nb;
        int done_cnt, done_cyc, we0;
        nb = life_step(model_b, birth_mask, survive_mask);
        for (int k = 0; k < 8; k++)
            exp_q.push_back('{addr: AW'(((exp_bank ? 0 : 1) * 8) + k), data: nb[8*k +: 8]});
        we0      = we_seen;
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        start_in = 1'b1;
        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            @(negedge clk);
            start_in = (cyc == xs0) || (cyc == xs1) || (cyc == xs2);
            if (cyc == 1 || cyc == GEN_CYC - 1) check("busy_during_gen", 64'(busy_out), 64'd1);
            if (done_out) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                check("busy_low_at_done", 64'(busy_out), 64'd0);
            end
            if (cyc == rst_at) begin
                #2 rst_n_in = 1'b0;
                #1 check_reset_outputs("async_reset_outputs");
                exp_q.delete();
                start_in = 1'b0;
                @(negedge clk);
                rst_n_in = 1'b1;
                exp_bank = 1'b0;
                return;
            end
        end
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_cycle", 64'(done_cyc), 64'(GEN_CYC));
        check("write_count", 64'(we_seen - we0), 64'd8);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_bank = ~exp_bank;
        check("buf_sel_after_gen", 64'(buf_sel_out), 64'(exp_bank));
        model_b = nb;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst_n_in = 1'b1; start_in = 1'b0; load_go = 1'b0; load_img = '0;
        n_cmp = 0; n_bad = 0; we_seen = 0; exp_bank = 1'b0; model_b = '0;
        birth_mask = 9'b000001000; survive_mask = 9'b000001100;

        // {initial board, generations, expected board in bank buf_sel afterwards}
        vecs[0] = '{64'h0020_0020_0020_0000, 4'd1, 64'h0000_0070_0000_0000};  // blinker
        vecs[1] = '{64'h0020_0020_0020_0000, 4'd2, 64'h0020_0020_0020_0000};  // blinker period 2
        vecs[2] = '{64'h8001_0000_0000_8001, 4'd3, 64'h8001_0000_0000_8001};  // block on both seams
        vecs[3] = '{64'h0000_0000_0000_0000, 4'd1, 64'h0000_0000_0000_0000};  // empty board

        for (int v = 0; v < 4; v++) begin
            do_reset();
            load_board(vecs[v].init_b);
            for (int g = 0; g < int'(vecs[v].gens); g++) run_gen(0, 0, 0, 0);
            check($sformatf("vec%0d_final_board", v), bank_img(buf_sel_out), vecs[v].final_b);
            check($sformatf("vec%0d_buf_sel", v), 64'(buf_sel_out), 64'(vecs[v].gens[0]));
        end

        // start pulses while busy and in the FIN cycle are dropped
        do_reset();
        load_board(vecs[0].init_b);
        run_gen(10, 68, 69, 0);
        check("ignored_starts_board", bank_img(1'b1), vecs[0].final_b);
        repeat (5) @(negedge clk);
        check("ignored_starts_idle", 64'({busy_out, done_out}), 64'd0);

        // async reset mid-generation, then a normal generation from bank 0
        do_reset();
        load_board(vecs[0].init_b);
        run_gen(0, 0, 0, 0);
        run_gen(0, 0, 0, 30);
        model_b = vecs[0].init_b;
        run_gen(0, 0, 0, 0);
        check("post_reset_board", bank_img(1'b1), vecs[0].final_b);

        // random soup, two generations against the reference model
        do_reset();
        load_board({$urandom, $urandom});
        run_gen(0, 0, 0, 0);
        run_gen(0, 0, 0, 0);
        check("random_final_board", bank_img(buf_sel_out), model_b);

`ifdef LIFE_RULE_CFG_EN
        // B36: dead cell (5,1) with six live neighbours is born
        birth_mask = 9'h048;
        do_reset();
        load_board(64'h0000_0070_0000_0070);
        run_gen(0, 0, 0, 0);
        check("b36_board", bank_img(1'b1), model_b);
        check("b36_cell_5_1", 64'(bank_img(1'b1)[21]), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
